// File: rtl/eth_pcs_rx_block_lock.sv
// 64b/66b RX block lock: sync-header lock FSM, gearbox bit-slip requests, optional high-BER monitor (ETH_PCS_RX_HI_BER_EN).
// Latency: one cycle from i_* to o_*; o_valid is qualified by lock (and by o_hi_ber when the monitor is built).
// No backpressure: i_valid is a clock enable from the gearbox; every strobed block is consumed.
module eth_pcs_rx_block_lock #(
   parameter int W_PAYLOAD    = 64,
   parameter int SH_CNT_MAX   = 64,
   parameter int SH_INVLD_MAX = 16,
   parameter int SLIP_WAIT    = 4,
   parameter int BER_WINDOW   = 19531,
   parameter int BER_THRESH   = 16
) (
   input  logic                 i_clk,
   input  logic                 i_reset_n,
   input  logic                 i_valid,
   input  logic [1:0]           i_sync_hdr,
   input  logic [W_PAYLOAD-1:0] i_payload,
   output logic                 o_slip,
   output logic                 o_block_lock,
   output logic                 o_valid,
   output logic [1:0]           o_sync_hdr,
   output logic [W_PAYLOAD-1:0] o_payload,
   output logic                 o_hi_ber
);

   localparam int SH_W   = $clog2(SH_CNT_MAX + 1);
   localparam int INV_W  = $clog2(SH_INVLD_MAX + 1);
   localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

   localparam logic [1:0] S_INIT      = 2'd0;
   localparam logic [1:0] S_TEST      = 2'd1;
   localparam logic [1:0] S_SLIP_WAIT = 2'd2;

   logic [1:0]        state, state_nxt;
   logic [SH_W-1:0]   sh_cnt, sh_nxt, sh_inc;
   logic [INV_W-1:0]  invld_cnt, inv_nxt, inv_inc;
   logic [WAIT_W-1:0] wait_cnt, wait_nxt, wait_inc;
   logic              lock_nxt, slip_nxt;
   logic              sh_ok;
   logic              valid_q;

   always_comb begin
      sh_ok     = (i_sync_hdr == 2'b01) || (i_sync_hdr == 2'b10);
      sh_inc    = sh_cnt + SH_W'(1);
      inv_inc   = invld_cnt + INV_W'(!sh_ok);
      wait_inc  = wait_cnt + WAIT_W'(1);
      state_nxt = state;
      sh_nxt    = sh_cnt;
      inv_nxt   = invld_cnt;
      wait_nxt  = wait_cnt;
      lock_nxt  = o_block_lock;
      slip_nxt  = 1'b0;
      case (state)
         S_INIT: begin
            sh_nxt    = '0;
            inv_nxt   = '0;
            wait_nxt  = '0;
            lock_nxt  = 1'b0;
            state_nxt = S_TEST;
         end
         S_TEST: begin
            if (i_valid) begin
               if (!o_block_lock) begin
                  if (!sh_ok) begin
                     slip_nxt  = 1'b1;
                     sh_nxt    = '0;
                     inv_nxt   = '0;
                     state_nxt = S_SLIP_WAIT;
                  end else if (sh_inc == SH_W'(SH_CNT_MAX)) begin
                     lock_nxt = 1'b1;
                     sh_nxt   = '0;
                  end else begin
                     sh_nxt = sh_inc;
                  end
               // invalid limit takes priority over a window ending on the same block
               end else if (inv_inc == INV_W'(SH_INVLD_MAX)) begin
                  lock_nxt  = 1'b0;
                  slip_nxt  = 1'b1;
                  sh_nxt    = '0;
                  inv_nxt   = '0;
                  state_nxt = S_SLIP_WAIT;
               end else if (sh_inc == SH_W'(SH_CNT_MAX)) begin
                  sh_nxt  = '0;
                  inv_nxt = '0;
               end else begin
                  sh_nxt  = sh_inc;
                  inv_nxt = inv_inc;
               end
            end
         end
         S_SLIP_WAIT: begin
            if (i_valid) begin
               if (wait_inc == WAIT_W'(SLIP_WAIT)) begin
                  wait_nxt  = '0;
                  state_nxt = S_TEST;
               end else begin
                  wait_nxt = wait_inc;
               end
            end
         end
         default: state_nxt = S_INIT;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state        <= S_INIT;
         sh_cnt       <= '0;
         invld_cnt    <= '0;
         wait_cnt     <= '0;
         o_block_lock <= 1'b0;
         o_slip       <= 1'b0;
         valid_q      <= 1'b0;
         o_sync_hdr   <= '0;
         o_payload    <= '0;
      end else begin
         state        <= state_nxt;
         sh_cnt       <= sh_nxt;
         invld_cnt    <= inv_nxt;
         wait_cnt     <= wait_nxt;
         o_block_lock <= lock_nxt;
         o_slip       <= slip_nxt;
         valid_q      <= i_valid & o_block_lock;
         if (i_valid) begin
            o_sync_hdr <= i_sync_hdr;
            o_payload  <= i_payload;
         end
      end
   end

`ifdef ETH_PCS_RX_HI_BER_EN
   localparam int TMR_W = $clog2(BER_WINDOW);
   localparam int BER_W = $clog2(BER_THRESH + 1);

   logic [TMR_W-1:0] ber_tmr;
   logic [BER_W-1:0] ber_cnt, ber_cnt_inc;
   logic             hi_ber_q;

   // the block arriving on the window's last cycle still counts toward that window
   always_comb begin
      ber_cnt_inc = ber_cnt;
      if (i_valid && !sh_ok && (ber_cnt != BER_W'(BER_THRESH)))
         ber_cnt_inc = ber_cnt + BER_W'(1);
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         ber_tmr  <= '0;
         ber_cnt  <= '0;
         hi_ber_q <= 1'b0;
      end else if (ber_tmr == TMR_W'(BER_WINDOW - 1)) begin
         ber_tmr  <= '0;
         ber_cnt  <= '0;
         hi_ber_q <= (ber_cnt_inc >= BER_W'(BER_THRESH));
      end else begin
         ber_tmr <= ber_tmr + TMR_W'(1);
         ber_cnt <= ber_cnt_inc;
      end
   end

   assign o_hi_ber = hi_ber_q;
   assign o_valid  = valid_q & ~hi_ber_q;
`else
   assign o_hi_ber = 1'b0;
   assign o_valid  = valid_q;
`endif

endmodule

// File: tb/tb_eth_pcs_rx_block_lock.sv
// Bench for eth_pcs_rx_block_lock: block-level reference model compared every cycle, plus directed literal checks.
module tb_eth_pcs_rx_block_lock;
   localparam int WP = 64, CNT_MAX = 64, INV_MAX = 16, WAITN = 4, BER_WIN = 100, BER_TH = 16;

   logic          i_clk = 1'b0, i_reset_n = 1'b0, i_valid = 1'b0;
   logic [1:0]    i_sync_hdr = 2'b00;
   logic [WP-1:0] i_payload = '0;
   logic          o_slip, o_block_lock, o_valid, o_hi_ber;
   logic [1:0]    o_sync_hdr;
   logic [WP-1:0] o_payload;

   eth_pcs_rx_block_lock #(
      .W_PAYLOAD(WP), .SH_CNT_MAX(CNT_MAX), .SH_INVLD_MAX(INV_MAX),
      .SLIP_WAIT(WAITN), .BER_WINDOW(BER_WIN), .BER_THRESH(BER_TH)
   ) dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .i_valid(i_valid), .i_sync_hdr(i_sync_hdr),
      .i_payload(i_payload), .o_slip(o_slip), .o_block_lock(o_block_lock), .o_valid(o_valid),
      .o_sync_hdr(o_sync_hdr), .o_payload(o_payload), .o_hi_ber(o_hi_ber)
   );

   always #5 i_clk = ~i_clk;

   int checks = 0, errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: tracks blocks seen, bad headers, blocks still to ignore after a slip.
   bit          m_init = 1'b1, m_locked = 1'b0, m_slip = 1'b0, m_vq = 1'b0, m_hi = 1'b0, m_bad;
   logic [1:0]  m_hdr = 2'b00;
   logic [63:0] m_pay = '0;
   int          m_ignore = 0, m_blocks = 0, m_bads = 0, m_tmr = 0, m_ber = 0;

   always @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         m_init = 1; m_locked = 0; m_slip = 0; m_vq = 0; m_hi = 0; m_hdr = 0; m_pay = 0;
         m_ignore = 0; m_blocks = 0; m_bads = 0; m_tmr = 0; m_ber = 0;
      end else begin
         m_bad  = i_valid && !(i_sync_hdr == 2'b01 || i_sync_hdr == 2'b10);
         m_vq   = i_valid && m_locked;
         m_slip = 0;
         if (i_valid) begin
            m_hdr = i_sync_hdr;
            m_pay = i_payload;
         end
         if (m_init) begin
            m_init = 0; m_locked = 0; m_blocks = 0; m_bads = 0; m_ignore = 0;
         end else if (i_valid) begin
            if (m_ignore > 0) begin
               m_ignore--;
            end else if (!m_locked) begin
               if (m_bad) begin
                  m_slip = 1; m_ignore = WAITN; m_blocks = 0;
               end else begin
                  m_blocks++;
                  if (m_blocks == CNT_MAX) begin m_locked = 1; m_blocks = 0; end
               end
            end else begin
               m_blocks++;
               if (m_bad) m_bads++;
               if (m_bads == INV_MAX) begin
                  m_locked = 0; m_slip = 1; m_ignore = WAITN; m_blocks = 0; m_bads = 0;
               end else if (m_blocks == CNT_MAX) begin
                  m_blocks = 0; m_bads = 0;
               end
            end
         end
         m_tmr++;
         if (m_bad && m_ber < BER_TH) m_ber++;
         if (m_tmr == BER_WIN) begin
            m_hi = (m_ber >= BER_TH); m_ber = 0; m_tmr = 0;
         end
      end
   end

   always @(negedge i_clk) begin
`ifdef ETH_PCS_RX_HI_BER_EN
      check("model_hi_ber", o_hi_ber, m_hi);
      check("model_valid", o_valid, m_vq && !m_hi);
`else
      check("model_hi_ber", o_hi_ber, 1'b0);
      check("model_valid", o_valid, m_vq);
`endif
      check("model_slip", o_slip, m_slip);
      check("model_lock", o_block_lock, m_locked);
      check("model_hdr", o_sync_hdr, m_hdr);
      check("model_payload", o_payload, m_pay);
   end

   logic [63:0] pcnt = 64'h100;

   task automatic send(input logic v, input logic [1:0] h, input logic [63:0] p);
      @(negedge i_clk);
      i_valid = v; i_sync_hdr = h; i_payload = p;
      @(posedge i_clk);
      #1;
   endtask

   task automatic good(input int n);
      for (int k = 0; k < n; k++) begin
         pcnt = pcnt + 64'd1;
         send(1'b1, pcnt[0] ? 2'b10 : 2'b01, pcnt);
      end
   endtask

   task automatic bad(input int n);
      for (int k = 0; k < n; k++) send(1'b1, 2'b00, 64'hBAD0 + 64'(k));
   endtask

   task automatic reset_zero_checks(input string tag);
      check({tag, "_slip"}, o_slip, 1'b0);
      check({tag, "_lock"}, o_block_lock, 1'b0);
      check({tag, "_valid"}, o_valid, 1'b0);
      check({tag, "_hdr"}, o_sync_hdr, 2'b00);
      check({tag, "_payload"}, o_payload, 64'h0);
      check({tag, "_hi_ber"}, o_hi_ber, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge i_clk);
      #2;
      i_reset_n = 1'b0; i_valid = 1'b0; i_sync_hdr = 2'b00;
      #1;
      reset_zero_checks("async_reset");
      @(negedge i_clk);
      #2;
      i_reset_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      #12;
      reset_zero_checks("reset_state");
      @(negedge i_clk);
      #2;
      i_reset_n = 1'b1;

      // clean lock acquisition
      good(63);
      check("lock_after_63", o_block_lock, 1'b0);
      good(1);
      check("lock_after_64", o_block_lock, 1'b1);
      check("valid_blk64", o_valid, 1'b0);
      good(1);
      check("valid_when_locked", o_valid, 1'b1);

      // reset while locked, then slip on block 10
      do_reset();
      good(9);
      send(1'b1, 2'b00, 64'hA);
      check("slip_blk10", o_slip, 1'b1);
      for (int k = 0; k < WAITN; k++) begin
         send(1'b1, 2'b11, 64'hB);
         check("no_slip_in_wait", o_slip, 1'b0);
      end
      good(63);
      check("relock_63", o_block_lock, 1'b0);
      good(1);
      check("relock_64", o_block_lock, 1'b1);

      // 15 invalid in a window holds lock, 16 drops it
      bad(15);
      good(49);
      check("held_15", o_block_lock, 1'b1);
      bad(15);
      good(10);
      bad(1);
      check("drop_16_lock", o_block_lock, 1'b0);
      check("drop_16_slip", o_slip, 1'b1);
      send(1'b0, 2'b00, 64'h0);
      check("slip_one_cycle", o_slip, 1'b0);

      // 16th invalid on the 64th block: invalid limit wins
      for (int k = 0; k < WAITN; k++) send(1'b1, 2'b11, 64'hC);
      good(64);
      check("lock_before_tie", o_block_lock, 1'b1);
      good(48);
      bad(15);
      check("tie_pre", o_block_lock, 1'b1);
      bad(1);
      check("tie_lock", o_block_lock, 1'b0);
      check("tie_slip", o_slip, 1'b1);

      // valid toggling with 2'b11 headers while locked
      for (int k = 0; k < WAITN; k++) send(1'b1, 2'b11, 64'hD);
      good(64);
      send(1'b1, 2'b11, 64'hDEAD_BEEF_0123_4567);
      check("payload_delay", o_payload, 64'hDEAD_BEEF_0123_4567);
      check("hdr_delay", o_sync_hdr, 2'b11);
      send(1'b0, 2'b11, 64'h1111_2222_3333_4444);
      check("payload_hold", o_payload, 64'hDEAD_BEEF_0123_4567);
      check("valid_gap", o_valid, 1'b0);
      for (int k = 1; k < 15; k++) begin
         send(1'b1, 2'b11, 64'(k));
         send(1'b0, 2'b11, 64'hFFFF);
      end
      check("toggle_held_15", o_block_lock, 1'b1);
      send(1'b1, 2'b11, 64'h77);
      check("toggle_drop_16", o_block_lock, 1'b0);
      check("toggle_slip", o_slip, 1'b1);

`ifdef ETH_PCS_RX_HI_BER_EN
      // timer windows end on posedges 100, 200, 300 after reset release
      do_reset();
      for (int p = 2; p <= 300; p++) begin
         send(1'b1, (p >= 122 && p <= 137) ? 2'b00 : 2'b01, 64'(p));
         if (p == 65)  check("ber_lock", o_block_lock, 1'b1);
         if (p == 199) begin
            check("ber_pre_hi", o_hi_ber, 1'b0);
            check("ber_pre_valid", o_valid, 1'b1);
         end
         if (p == 200) begin
            check("ber_hi", o_hi_ber, 1'b1);
            check("ber_valid_forced", o_valid, 1'b0);
            check("ber_lock_held", o_block_lock, 1'b1);
         end
         if (p == 300) begin
            check("ber_clear", o_hi_ber, 1'b0);
            check("ber_valid_back", o_valid, 1'b1);
         end
      end
`endif

      send(1'b0, 2'b00, 64'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
